// File: rtl/jk_count_ctrl.sv
// jk_count_ctrl: sequencer for a bank of WIDTH JK flip-flops.
// Takes one command at a time over valid/ready: either a parallel load or a
// count of N steps up or down. It drives the J/K vector for every cycle and
// holds the bank state itself.
// Optional feature macro: JK_ABORT_EN adds an 'abort' input. When abort is high
// during LOAD or RUN, the command ends early and passes through DONE.
module jk_count_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef JK_ABORT_EN
  input  logic             abort,
`endif
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic             cmd_dir,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qc,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] rem_r;
  logic             dir_r;
  logic [WIDTH-1:0] tog_c;
  logic             abort_c;

  // Abort matters only while a command is active.
`ifdef JK_ABORT_EN
  assign abort_c = abort & ((state == S_LOAD) | (state == S_RUN));
`else
  assign abort_c = 1'b0;
`endif

  assign qc = ~q;

  // Toggle mask for a single count step: bit i flips when all lower bits are
  // ones (up) or all lower bits are zeros (down).
  always_comb begin
    logic carry;
    carry = 1'b1;
    tog_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      tog_c[i] = carry;
      carry    = carry & (dir_r ? q[i] : ~q[i]);
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_load)              state_nxt = S_LOAD;
          else if (cmd_data != '0)   state_nxt = S_RUN;
          else                       state_nxt = S_DONE;
        end
      end
      S_LOAD:  state_nxt = S_DONE;
      S_RUN:   if (abort_c || rem_r == WIDTH'(1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // J/K vector applied to the bank at the coming edge.
  always_comb begin
    j = '0;
    k = '0;
    case (state)
      S_LOAD: begin
        j = data_r;
        k = ~data_r;
      end
      S_RUN: begin
        j = tog_c;
        k = tog_c;
      end
      default: ;
    endcase
    if (abort_c) begin
      j = '0;
      k = '0;
    end
  end

  // State, bank, command latches and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      q         <= '0;
      data_r    <= '0;
      rem_r     <= '0;
      dir_r     <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state     <= state_nxt;
      q         <= (j & ~q) | (~k & q);
      cmd_ready <= (state_nxt == S_IDLE);
      busy      <= (state_nxt == S_LOAD) || (state_nxt == S_RUN);
      done      <= (state_nxt == S_DONE);
      wrap      <= (state == S_RUN) && !abort_c && (dir_r ? (&q) : ~(|q));
      if (state == S_IDLE && cmd_valid) begin
        data_r <= cmd_data;
        rem_r  <= cmd_data;
        dir_r  <= cmd_dir;
      end else if (state == S_RUN) begin
        rem_r  <= rem_r - WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_jk_count_ctrl.sv
// Self-checking bench for jk_count_ctrl (WIDTH=4). The reference model keeps the
// bank value as a 4-bit number. It applies each command as arithmetic (load, +1 or
// -1 per step) and derives the expected J/K from the bits that must change.
module tb_jk_count_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_load = 1'b0;
  logic       cmd_dir = 1'b0;
  logic [3:0] cmd_data = 4'h0;
  logic       cmd_ready;
  logic [3:0] q, qc, j, k;
  logic       busy, done, wrap;
`ifdef JK_ABORT_EN
  logic       abort = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  logic [3:0] mq = 4'h0;

  always #5 clk = ~clk;

  jk_count_ctrl #(.WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
`ifdef JK_ABORT_EN
    .abort(abort),
`endif
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_load(cmd_load),
    .cmd_dir(cmd_dir),
    .cmd_data(cmd_data),
    .q(q),
    .qc(qc),
    .j(j),
    .k(k),
    .busy(busy),
    .done(done),
    .wrap(wrap)
  );

  // Issue one command, then check every cycle up to the return to idle.
  // While the command runs, cmd_valid toggles at random with random data,
  // and the DUT must ignore it.
  task automatic do_cmd(input string tag, input logic ld, input logic up, input logic [3:0] d);
    int         nb;
    logic [3:0] nxt, ej, ek;
    logic       ew;
    nb = ld ? 1 : int'(d);
    cmd_valid = 1'b1; cmd_load = ld; cmd_dir = up; cmd_data = d;
    @(posedge clk); #1;
    for (int i = 0; i <= nb + 1; i++) begin
      ew = 1'b0;
      if (ld) begin
        if (i == 1) mq = d;
      end else if (i >= 1 && i <= nb) begin
        ew = up ? (mq == 4'hF) : (mq == 4'h0);
        mq = up ? 4'(mq + 4'd1) : 4'(mq - 4'd1);
      end
      ej = 4'h0; ek = 4'h0;
      if (i < nb) begin
        if (ld) begin
          ej = d; ek = ~d;
        end else begin
          nxt = up ? 4'(mq + 4'd1) : 4'(mq - 4'd1);
          ej = mq ^ nxt; ek = ej;
        end
      end
      checks++;
      if (q !== mq || qc !== ~mq) begin
        errors++;
        $display("FAIL %s q cyc%0d: got q=%h qc=%h want q=%h qc=%h", tag, i, q, qc, mq, ~mq);
      end
      checks++;
      if (j !== ej || k !== ek) begin
        errors++;
        $display("FAIL %s jk cyc%0d: got j=%h k=%h want j=%h k=%h", tag, i, j, k, ej, ek);
      end
      checks++;
      if ({cmd_ready, busy, done, wrap} !== {i == nb + 1, i < nb, i == nb, ew}) begin
        errors++;
        $display("FAIL %s status cyc%0d: got rdy/busy/done/wrap=%b want %b", tag, i,
                 {cmd_ready, busy, done, wrap}, {i == nb + 1, i < nb, i == nb, ew});
      end
      if (i <= nb) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_load  = 1'($urandom_range(0, 1));
        cmd_dir   = 1'($urandom_range(0, 1));
        cmd_data  = 4'($urandom);
        @(posedge clk); #1;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mq = 4'h0;
    checks++;
    if ({q, qc, j, k} !== {4'h0, 4'hF, 4'h0, 4'h0}) begin
      errors++;
      $display("FAIL reset bank: got q=%h qc=%h j=%h k=%h want 0 f 0 0", q, qc, j, k);
    end
    checks++;
    if ({cmd_ready, busy, done, wrap} !== 4'b1000) begin
      errors++;
      $display("FAIL reset status: got rdy/busy/done/wrap=%b want 1000", {cmd_ready, busy, done, wrap});
    end
  endtask

  task automatic test_load();
    do_cmd("load_a", 1'b1, 1'b0, 4'hA);
  endtask

  task automatic test_up_count();
    do_cmd("load_d", 1'b1, 1'b0, 4'hD);
    do_cmd("up5", 1'b0, 1'b1, 4'd5);
  endtask

  task automatic test_down_count();
    do_cmd("load_1", 1'b1, 1'b0, 4'h1);
    do_cmd("down3", 1'b0, 1'b0, 4'd3);
  endtask

  task automatic test_zero_and_max();
    do_cmd("zero", 1'b0, 1'b1, 4'd0);
    do_cmd("max_up", 1'b0, 1'b1, 4'd15);
    do_cmd("max_down", 1'b0, 1'b0, 4'd15);
  endtask

  task automatic test_reset_abort();
    do_cmd("load_3", 1'b1, 1'b0, 4'h3);
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_dir = 1'b1; cmd_data = 4'd6;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q !== 4'h5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort pre: got q=%h busy=%b want q=5 busy=1", q, busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mq = 4'h0;
    checks++;
    if ({q, cmd_ready, busy, done, wrap} !== {4'h0, 4'b1000}) begin
      errors++;
      $display("FAIL abort rst: got q=%h rdy/busy/done/wrap=%b want q=0 1000", q, {cmd_ready, busy, done, wrap});
    end
    @(posedge clk); #1;
    checks++;
    if ({q, cmd_ready, busy, done} !== {4'h0, 3'b100}) begin
      errors++;
      $display("FAIL abort after: got q=%h rdy/busy/done=%b want q=0 100", q, {cmd_ready, busy, done});
    end
  endtask

  task automatic test_random();
    logic       ld;
    for (int n = 0; n < 25; n++) begin
      ld = ($urandom_range(0, 2) == 0);
      do_cmd("rand", ld, 1'($urandom_range(0, 1)), 4'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_up_count();
    test_down_count();
    test_zero_and_max();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
